// File: rtl/control_multiplicador.sv
// Moore sequencer for the shift-add multiplier datapath: issues load/clear,
// add and shift strobes, then holds DONE for DONE_CYCLES clocks.
module control_multiplicador #(
  parameter int WIDTH       = 8,
  parameter int DONE_CYCLES = 32,
  parameter int EARLY_EXIT  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic INIT,
  input  logic LSB,
  input  logic Z,
  output logic LD,
  output logic RST_ACC,
  output logic ADD,
  output logic SH,
  output logic BUSY,
  output logic DONE
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH);
  localparam logic [7:0]    DONE_LAST = 8'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_CHECK = 3'b010,
    S_ADD   = 3'b011,
    S_SHIFT = 3'b100,
    S_END   = 3'b101
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]      done_cnt_q, done_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    done_cnt_d = done_cnt_q;
    case (state_q)
      S_IDLE: begin
        done_cnt_d = '0;
        if (INIT) state_d = S_LOAD;
      end
      S_LOAD: begin
        bit_cnt_d = '0;
        state_d   = S_CHECK;
      end
      S_CHECK: begin
        // the iteration limit wins over Z so bit_cnt can never pass WIDTH
        if (bit_cnt_q == BIT_LAST)      state_d = S_END;
        else if (EARLY_EXIT != 0 && Z)  state_d = S_END;
        else if (LSB)                   state_d = S_ADD;
        else                            state_d = S_SHIFT;
      end
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        state_d   = S_CHECK;
      end
      S_END: begin
        if (done_cnt_q == DONE_LAST) begin
          done_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          done_cnt_d = done_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // strobes decode from state only; unused codes drive everything low
  always_comb begin
    LD      = 1'b0;
    RST_ACC = 1'b0;
    ADD     = 1'b0;
    SH      = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      S_LOAD:  begin LD = 1'b1; RST_ACC = 1'b1; BUSY = 1'b1; end
      S_CHECK: BUSY = 1'b1;
      S_ADD:   begin ADD = 1'b1; BUSY = 1'b1; end
      S_SHIFT: begin SH = 1'b1; BUSY = 1'b1; end
      S_END:   begin DONE = 1'b1; BUSY = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_multiplicador.sv
// Bench for control_multiplicador: three instances (W4/EE1, W8/EE1, W8/EE0), each
// with a small multiplier-register model; a monitor checks per-cycle output words.
module tb_control_multiplicador;

  logic clk, rst_n;
  logic init [3];
  logic [7:0] opnd [3];
  logic ld [3], rst_acc [3], add [3], sh [3], busy [3], done [3];

  logic [5:0] expq [3][$];
  int checks = 0;
  int errors = 0;
  logic [5:0] e_w, a_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] mreg;
    control_multiplicador #(
      .WIDTH(g == 0 ? 4 : 8), .DONE_CYCLES(32), .EARLY_EXIT(g == 2 ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .INIT(init[g]), .LSB(mreg[0]), .Z(mreg == 8'd0),
      .LD(ld[g]), .RST_ACC(rst_acc[g]), .ADD(add[g]), .SH(sh[g]),
      .BUSY(busy[g]), .DONE(done[g])
    );
    always @(posedge clk) begin
      if (ld[g])      mreg <= opnd[g];
      else if (sh[g]) mreg <= mreg >> 1;
    end
  end

  // word layout {LD, RST_ACC, ADD, SH, BUSY, DONE}
  function automatic logic [5:0] code(input byte c);
    case (c)
      "L":     return 6'b110010;
      "C":     return 6'b000010;
      "A":     return 6'b001010;
      "S":     return 6'b000110;
      "D":     return 6'b000011;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic push_ops(input int d, input string s, input int nd, input int ni);
    for (int i = 0; i < s.len(); i++) expq[d].push_back(code(s[i]));
    repeat (nd) expq[d].push_back(code("D"));
    repeat (ni) expq[d].push_back(6'b000000);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (expq[i].size() != 0) begin
        e_w = expq[i].pop_front();
        a_w = {ld[i], rst_acc[i], add[i], sh[i], busy[i], done[i]};
        checks++;
        if (a_w !== e_w) begin
          errors++;
          $display("FAIL seq dut%0d t=%0t got %b want %b", i, $time, a_w, e_w);
        end
      end
    end
  end

  task automatic chk_zero(input string name, input int d);
    logic [5:0] a;
    a = {ld[d], rst_acc[d], add[d], sh[d], busy[d], done[d]};
    checks++;
    if (a !== 6'b000000) begin
      errors++;
      $display("FAIL %s dut%0d got %b want 000000", name, d, a);
    end
  endtask

  task automatic start(input int d, input logic [7:0] op, input string s);
    @(negedge clk);
    opnd[d] = op;
    init[d] = 1'b1;
    @(posedge clk);
    #1;
    init[d] = 1'b0;
    push_ops(d, s, (s.len() > 3) ? 32 : 0, (s.len() > 3) ? 1 : 0);
  endtask

  task automatic drain();
    int g = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 3000) begin
      errors++;
      $display("FAIL drain timeout left %0d want 0",
               expq[0].size() + expq[1].size() + expq[2].size());
    end
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin init[i] = 1'b0; opnd[i] = 8'h00; end
    #1;
    for (int i = 0; i < 3; i++) chk_zero("reset_state", i);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // async reset while in S_ADD (cycle 3 of a 1011 run)
    start(0, 8'h0B, "LCA");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_abort", 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push_ops(0, "", 0, 4);
    drain();

    // WIDTH=4, multiplier 1011
    start(0, 8'h0B, "LCASCASCSCASC");
    drain();
    // early exit on zero multiplier
    start(1, 8'h00, "LC");
    push_ops(1, "", 32, 1);
    drain();
    // EARLY_EXIT=0, zero multiplier: 8 shifts, no adds
    start(2, 8'h00, "LCSCSCSCSCSCSCSCSC");
    drain();
    // EARLY_EXIT=0, all ones: each add followed by a shift
    start(2, 8'hFF, "LCASCASCASCASCASCASCASCASC");
    drain();

    // INIT toggled while busy, then held high across the end of DONE
    @(negedge clk);
    opnd[0] = 8'h02;
    init[0] = 1'b1;
    @(posedge clk);
    #1;
    push_ops(0, "LCSCASC", 32, 1);
    push_ops(0, "LCSCASC", 32, 2);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      init[0] = ~init[0];
    end
    init[0] = 1'b1;
    repeat (15) @(negedge clk);
    init[0] = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
